// File: rtl/butterfly_pipe.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// butterfly_pipe
//   Pipelined radix-2 DIF butterfly:  X1 = x1 + x2,  X2 = (x1 - x2) * W.
//   Three registered stages (sum/diff, products, combine+round+reduce), each
//   with its own valid bit and a ready chain that lets the pipe hold up to
//   three pairs under backpressure without dropping or reordering them.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   input handshake; x1/x2/w/inv/scale sampled on transfer
//   x1_r..x2_i          DW-bit signed operands
//   w_r, w_i            TW-bit signed twiddle, FRAC fractional bits
//   inv                 1 = multiply by conj(W) (inverse FFT)
//   scale               1 = halve both outputs (rounded)
//   out_valid/out_ready output handshake; results hold while stalled
//   X1_r..X2_i          DW-bit signed results (saturated or wrapped by SAT)
//   ovf, ovf_clr        sticky "a result did not fit" flag and its clear
// -----------------------------------------------------------------------------
module butterfly_pipe #(
  parameter int DW   = 12,
  parameter int TW   = 12,
  parameter int FRAC = 10,
  parameter int SAT  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] x1_r,
  input  logic signed [DW-1:0] x1_i,
  input  logic signed [DW-1:0] x2_r,
  input  logic signed [DW-1:0] x2_i,
  input  logic signed [TW-1:0] w_r,
  input  logic signed [TW-1:0] w_i,
  input  logic                 inv,
  input  logic                 scale,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] X1_r,
  output logic signed [DW-1:0] X1_i,
  output logic signed [DW-1:0] X2_r,
  output logic signed [DW-1:0] X2_i,
  output logic                 ovf,
  input  logic                 ovf_clr
);

  // Sum/difference width, widened twiddle, product width, combine width.
  // The combine width carries two guard bits: one for ac-bd / ad+bc and one
  // for the rounding increment, so nothing is lost before reduction.
  localparam int SW = DW + 1;
  localparam int WW = TW + 1;
  localparam int PW = SW + WW;
  localparam int CW = PW + 2;

  localparam logic signed [CW-1:0] ONE_C     = {{(CW-1){1'b0}}, 1'b1};
  localparam logic signed [CW-1:0] HALF_C    = ONE_C <<< (FRAC - 1);
  localparam logic signed [CW-1:0] HALF_SC_C = ONE_C <<< FRAC;
  localparam logic signed [CW-1:0] MAX_C     = {{(CW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [CW-1:0] MIN_C     = {{(CW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  // True when v is representable in DW signed bits.
  function automatic logic fits_dw(input logic signed [CW-1:0] v);
    return (v >= MIN_C) && (v <= MAX_C);
  endfunction

  // Clamp (SAT != 0) or keep the low DW bits (SAT == 0).
  function automatic logic signed [DW-1:0] reduce_dw(input logic signed [CW-1:0] v);
    logic signed [DW-1:0] r;
    if ((SAT != 0) && (v > MAX_C)) begin
      r = MAX_C[DW-1:0];
    end else if ((SAT != 0) && (v < MIN_C)) begin
      r = MIN_C[DW-1:0];
    end else begin
      r = v[DW-1:0];
    end
    return r;
  endfunction

  // Product path: add half an LSB of the target scale, then arithmetic shift
  // (round half toward +inf). scale adds one more bit of shift.
  function automatic logic signed [CW-1:0] round_x2(input logic signed [CW-1:0] p,
                                                    input logic              sc);
    logic signed [CW-1:0] r;
    if (sc) begin
      r = (p + HALF_SC_C) >>> (FRAC + 1);
    end else begin
      r = (p + HALF_C) >>> FRAC;
    end
    return r;
  endfunction

  // Sum path: pass through, or (sum + 1) >>> 1 when halving.
  function automatic logic signed [CW-1:0] round_x1(input logic signed [SW-1:0] s,
                                                    input logic              sc);
    logic signed [CW-1:0] e;
    logic signed [CW-1:0] r;
    e = CW'(s);
    if (sc) begin
      r = (e + ONE_C) >>> 1;
    end else begin
      r = e;
    end
    return r;
  endfunction

  // ---------------------------------------------------------------- control
  logic s1_valid_r;
  logic s2_valid_r;
  logic en1_s;
  logic en2_s;
  logic en3_s;
  logic ld3_s;

  // A stage may load when it is empty or its content moves on this cycle.
  assign en3_s    = !out_valid || out_ready;
  assign en2_s    = !s2_valid_r || en3_s;
  assign en1_s    = !s1_valid_r || en2_s;
  assign ld3_s    = en3_s && s2_valid_r;
  assign in_ready = en1_s;

  // Valid bits of the three stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s2_valid_r <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      if (en1_s) s1_valid_r <= in_valid;
      if (en2_s) s2_valid_r <= s1_valid_r;
      if (en3_s) out_valid  <= s2_valid_r;
    end
  end

  // ---------------------------------------------------------------- stage 1
  logic signed [SW-1:0] sum_re_s, sum_im_s, dif_re_s, dif_im_s;
  logic signed [SW-1:0] s1_sum_re_r, s1_sum_im_r, s1_dif_re_r, s1_dif_im_r;
  logic signed [TW-1:0] s1_w_re_r, s1_w_im_r;
  logic                 s1_inv_r, s1_scale_r;

  assign sum_re_s = SW'(x1_r) + SW'(x2_r);
  assign sum_im_s = SW'(x1_i) + SW'(x2_i);
  assign dif_re_s = SW'(x1_r) - SW'(x2_r);
  assign dif_im_s = SW'(x1_i) - SW'(x2_i);

  // Stage 1 registers: capture sums, differences and twiddle on input transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_sum_re_r <= {SW{1'b0}};
      s1_sum_im_r <= {SW{1'b0}};
      s1_dif_re_r <= {SW{1'b0}};
      s1_dif_im_r <= {SW{1'b0}};
      s1_w_re_r   <= {TW{1'b0}};
      s1_w_im_r   <= {TW{1'b0}};
      s1_inv_r    <= 1'b0;
      s1_scale_r  <= 1'b0;
    end else if (en1_s && in_valid) begin
      s1_sum_re_r <= sum_re_s;
      s1_sum_im_r <= sum_im_s;
      s1_dif_re_r <= dif_re_s;
      s1_dif_im_r <= dif_im_s;
      s1_w_re_r   <= w_r;
      s1_w_im_r   <= w_i;
      s1_inv_r    <= inv;
      s1_scale_r  <= scale;
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic signed [WW-1:0] wi_ext_s;
  logic signed [WW-1:0] wi_eff_s;
  logic signed [PW-1:0] a_s, b_s, c_s, d_s;
  logic signed [PW-1:0] ac_s, bd_s, ad_s, bc_s;
  logic signed [PW-1:0] s2_ac_r, s2_bd_r, s2_ad_r, s2_bc_r;
  logic signed [SW-1:0] s2_sum_re_r, s2_sum_im_r;
  logic                 s2_scale_r;

  // Imaginary twiddle widened by one bit first so that negating the most
  // negative TW-bit value is exact.
  assign wi_ext_s = WW'(s1_w_im_r);

  // Conjugate twiddle for the inverse transform.
  always_comb begin
    wi_eff_s = wi_ext_s;
    if (s1_inv_r) begin
      wi_eff_s = -wi_ext_s;
    end else begin
      wi_eff_s = wi_ext_s;
    end
  end

  assign a_s  = PW'(s1_dif_re_r);
  assign b_s  = PW'(s1_dif_im_r);
  assign c_s  = PW'(s1_w_re_r);
  assign d_s  = PW'(wi_eff_s);
  assign ac_s = a_s * c_s;
  assign bd_s = b_s * d_s;
  assign ad_s = a_s * d_s;
  assign bc_s = b_s * c_s;

  // Stage 2 registers: four partial products plus the delayed sums.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_ac_r     <= {PW{1'b0}};
      s2_bd_r     <= {PW{1'b0}};
      s2_ad_r     <= {PW{1'b0}};
      s2_bc_r     <= {PW{1'b0}};
      s2_sum_re_r <= {SW{1'b0}};
      s2_sum_im_r <= {SW{1'b0}};
      s2_scale_r  <= 1'b0;
    end else if (en2_s && s1_valid_r) begin
      s2_ac_r     <= ac_s;
      s2_bd_r     <= bd_s;
      s2_ad_r     <= ad_s;
      s2_bc_r     <= bc_s;
      s2_sum_re_r <= s1_sum_re_r;
      s2_sum_im_r <= s1_sum_im_r;
      s2_scale_r  <= s1_scale_r;
    end
  end

  // ---------------------------------------------------------------- stage 3
  logic signed [CW-1:0] re_full_s, im_full_s;
  logic signed [CW-1:0] x1re_s, x1im_s, x2re_s, x2im_s;
  logic                 ovf_hit_s;

  assign re_full_s = CW'(s2_ac_r) - CW'(s2_bd_r);
  assign im_full_s = CW'(s2_ad_r) + CW'(s2_bc_r);
  assign x1re_s    = round_x1(s2_sum_re_r, s2_scale_r);
  assign x1im_s    = round_x1(s2_sum_im_r, s2_scale_r);
  assign x2re_s    = round_x2(re_full_s, s2_scale_r);
  assign x2im_s    = round_x2(im_full_s, s2_scale_r);
  assign ovf_hit_s = !fits_dw(x1re_s) || !fits_dw(x1im_s) ||
                     !fits_dw(x2re_s) || !fits_dw(x2im_s);

  // Output registers: load only when stage 3 accepts, so they hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      X1_r <= {DW{1'b0}};
      X1_i <= {DW{1'b0}};
      X2_r <= {DW{1'b0}};
      X2_i <= {DW{1'b0}};
    end else if (ld3_s) begin
      X1_r <= reduce_dw(x1re_s);
      X1_i <= reduce_dw(x1im_s);
      X2_r <= reduce_dw(x2re_s);
      X2_i <= reduce_dw(x2im_s);
    end
  end

  // Sticky overflow: a new overflow on stage-3 load beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (ld3_s && ovf_hit_s) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_butterfly_pipe.sv
`timescale 1ns/1ps
module tb_butterfly_pipe;

  localparam int DW   = 12;
  localparam int TW   = 12;
  localparam int FRAC = 10;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid, in_ready, in_ready_w;
  logic signed [DW-1:0] x1_r, x1_i, x2_r, x2_i;
  logic signed [TW-1:0] w_r, w_i;
  logic                 inv, scale;
  logic                 out_valid, out_valid_w, out_ready;
  logic signed [DW-1:0] X1_r, X1_i, X2_r, X2_i;
  logic signed [DW-1:0] X1_r_w, X1_i_w, X2_r_w, X2_i_w;
  logic                 ovf, ovf_w, ovf_clr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  butterfly_pipe #(.DW(DW), .TW(TW), .FRAC(FRAC), .SAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x1_r(x1_r), .x1_i(x1_i), .x2_r(x2_r), .x2_i(x2_i), .w_r(w_r), .w_i(w_i),
    .inv(inv), .scale(scale), .out_valid(out_valid), .out_ready(out_ready),
    .X1_r(X1_r), .X1_i(X1_i), .X2_r(X2_r), .X2_i(X2_i),
    .ovf(ovf), .ovf_clr(ovf_clr)
  );

  butterfly_pipe #(.DW(DW), .TW(TW), .FRAC(FRAC), .SAT(0)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
    .x1_r(x1_r), .x1_i(x1_i), .x2_r(x2_r), .x2_i(x2_i), .w_r(w_r), .w_i(w_i),
    .inv(inv), .scale(scale), .out_valid(out_valid_w), .out_ready(out_ready),
    .X1_r(X1_r_w), .X1_i(X1_i_w), .X2_r(X2_r_w), .X2_i(X2_i_w),
    .ovf(ovf_w), .ovf_clr(ovf_clr)
  );

  // Expected result of one pair: [0]=X1_r [1]=X1_i [2]=X2_r [3]=X2_i
  typedef struct packed {
    logic [3:0][31:0] sat_v;
    logic [3:0][31:0] wrap_v;
    logic             ovf;
  } exp_t;

  exp_t q[$];
  bit   sticky = 1'b0;
  int   n_in   = 0;
  int   n_out  = 0;

  task automatic chk(input string tag, input longint obs, input longint expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference: complex arithmetic on plain integers, then clamp / modulo.
  function automatic exp_t model(input int a1r, a1i, a2r, a2i, wr, wi, input bit iv, sc);
    exp_t   e;
    longint v[4];
    longint sr, si, dr, di, wie, pr, pi, hi, lo, m, wv;
    int     sh;
    sr  = a1r + a2r;
    si  = a1i + a2i;
    dr  = a1r - a2r;
    di  = a1i - a2i;
    wie = iv ? -longint'(wi) : longint'(wi);
    pr  = dr * wr - di * wie;
    pi  = dr * wie + di * wr;
    sh  = FRAC + int'(sc);
    v[0] = sc ? ((sr + 1) >>> 1) : sr;
    v[1] = sc ? ((si + 1) >>> 1) : si;
    v[2] = (pr + (longint'(1) << (sh - 1))) >>> sh;
    v[3] = (pi + (longint'(1) << (sh - 1))) >>> sh;
    hi = (longint'(1) << (DW - 1)) - 1;
    lo = -(longint'(1) << (DW - 1));
    m  = longint'(1) << DW;
    e  = '0;
    for (int k = 0; k < 4; k++) begin
      if (v[k] > hi) begin
        e.sat_v[k] = 32'(hi);
        e.ovf = 1'b1;
      end else if (v[k] < lo) begin
        e.sat_v[k] = 32'(lo);
        e.ovf = 1'b1;
      end else begin
        e.sat_v[k] = 32'(v[k]);
      end
      wv = v[k] & (m - 1);
      if (wv > hi) wv = wv - m;
      e.wrap_v[k] = 32'(wv);
    end
    return e;
  endfunction

  // Monitor: scoreboard of accepted pairs versus delivered results.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
      sticky = 1'b0;
    end else begin
      chk("in_ready", longint'(in_ready), (q.size() == 3 && !out_ready) ? 0 : 1);
      if (out_valid) begin
        chk("valid_has_pending", longint'(q.size() > 0), 1);
        if (q.size() > 0) begin
          e = q[0];
          chk("X1_r", X1_r, $signed(e.sat_v[0]));
          chk("X1_i", X1_i, $signed(e.sat_v[1]));
          chk("X2_r", X2_r, $signed(e.sat_v[2]));
          chk("X2_i", X2_i, $signed(e.sat_v[3]));
          chk("wrap_X1_r", X1_r_w, $signed(e.wrap_v[0]));
          chk("wrap_X1_i", X1_i_w, $signed(e.wrap_v[1]));
          chk("wrap_X2_r", X2_r_w, $signed(e.wrap_v[2]));
          chk("wrap_X2_i", X2_i_w, $signed(e.wrap_v[3]));
          chk("ovf", longint'(ovf), longint'(sticky | e.ovf));
          chk("wrap_ovf", longint'(ovf_w), longint'(sticky | e.ovf));
          if (out_ready) begin
            void'(q.pop_front());
            sticky = sticky | e.ovf;
            n_out++;
          end
        end
      end
      if (ovf_clr) sticky = 1'b0;
      if (in_valid && in_ready) begin
        q.push_back(model(int'(x1_r), int'(x1_i), int'(x2_r), int'(x2_i),
                          int'(w_r), int'(w_i), inv, scale));
        n_in++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int a1r, a1i, a2r, a2i, wr, wi, input bit iv, sc);
    x1_r  = DW'(a1r);
    x1_i  = DW'(a1i);
    x2_r  = DW'(a2r);
    x2_i  = DW'(a2i);
    w_r   = TW'(wr);
    w_i   = TW'(wi);
    inv   = iv;
    scale = sc;
  endtask

  task automatic set_rand();
    set_in(int'($urandom), int'($urandom), int'($urandom), int'($urandom),
           int'($urandom), int'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // One pair into an empty pipe; checks the three-cycle latency and leaves
  // the result on the outputs.
  task automatic lat_pair(input string tag, input int a1r, a1i, a2r, a2i, wr, wi,
                          input bit iv, sc);
    out_ready = 1'b1;
    set_in(a1r, a1i, a2r, a2i, wr, wi, iv, sc);
    in_valid = 1'b1;
    chk({tag, "_in_ready"}, longint'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    chk({tag, "_lat1"}, longint'(out_valid), 0);
    tick();
    chk({tag, "_lat2"}, longint'(out_valid), 0);
    tick();
    chk({tag, "_lat3"}, longint'(out_valid), 1);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int  sent;
    int  base;
    bit  saw_block;
    bit  acc;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    tick(); tick();
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_ovf", longint'(ovf), 0);
    chk("rst_X1_r", X1_r, 0);
    chk("rst_X2_i", X2_i, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", longint'(in_ready), 1);

    lat_pair("basic", 100, 0, 40, 0, 1024, 0, 1'b0, 1'b0);
    chk("basic_X1_r", X1_r, 140);
    chk("basic_X2_r", X2_r, 60);
    chk("basic_ovf", longint'(ovf), 0);

    lat_pair("fwd", 100, 0, 40, 0, 0, 1024, 1'b0, 1'b0);
    chk("fwd_X2_i", X2_i, 60);
    chk("fwd_X1_r", X1_r, 140);
    lat_pair("inv", 100, 0, 40, 0, 0, 1024, 1'b1, 1'b0);
    chk("inv_X2_i", X2_i, -60);
    chk("inv_X1_r", X1_r, 140);

    lat_pair("rnd_up", 1, 0, 0, 0, 512, 0, 1'b0, 1'b0);
    chk("rnd_up_X2_r", X2_r, 1);
    lat_pair("rnd_neg", 0, 0, 1, 0, 512, 0, 1'b0, 1'b0);
    chk("rnd_neg_X2_r", X2_r, 0);
    lat_pair("scale", 101, 0, 0, 0, 1024, 0, 1'b0, 1'b1);
    chk("scale_X1_r", X1_r, 51);
    chk("scale_X2_r", X2_r, 51);
    lat_pair("minw_inv", 7, 3, 2, -5, -2048, -2048, 1'b1, 1'b0);

    lat_pair("sat", 2047, 0, 2047, 0, 1024, 0, 1'b0, 1'b0);
    chk("sat_X1_r", X1_r, 2047);
    chk("wrap_X1_r_direct", X1_r_w, -2);
    chk("sat_ovf", longint'(ovf), 1);
    chk("wrap_ovf_direct", longint'(ovf_w), 1);
    tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_cleared", longint'(ovf), 0);
    chk("wrap_ovf_cleared", longint'(ovf_w), 0);

    // Six back-to-back pairs with the output stalled for cycles 2..8.
    sent = 0; saw_block = 1'b0; base = n_out;
    set_rand();
    for (int k = 0; k < 40; k++) begin
      out_ready = !(k >= 2 && k <= 8);
      in_valid  = (sent < 6);
      #1;
      if (k >= 3 && k <= 8 && !in_ready) saw_block = 1'b1;
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        sent++;
        set_rand();
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_blocked", longint'(saw_block), 1);
    chk("bp_sent", sent, 6);
    chk("bp_delivered", n_out - base, 6);
    chk("bp_drained", q.size(), 0);

    // Random traffic with random backpressure.
    for (int k = 0; k < 400; k++) begin
      set_rand();
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) tick();
    chk("rand_in_eq_out", n_in, n_out);
    chk("rand_drained", q.size(), 0);

    // Asynchronous reset with two pairs in flight and ovf set.
    lat_pair("pre_rst_sat", 2047, 0, 2047, 0, 1024, 0, 1'b0, 1'b0);
    tick();
    set_in(5, 6, 7, 8, 900, -300, 1'b0, 1'b0);
    in_valid = 1'b1;
    tick();
    set_in(-9, 4, 3, -2, 100, 700, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    chk("mid_out_valid_before", longint'(out_valid), 1);
    chk("mid_ovf_before", longint'(ovf), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", longint'(out_valid), 0);
    chk("mid_rst_ovf", longint'(ovf), 0);
    chk("mid_rst_wrap_ovf", longint'(ovf_w), 0);
    chk("mid_rst_X1_r", X1_r, 0);
    tick();
    rst_n = 1'b1;
    chk("mid_rel_in_ready", longint'(in_ready), 1);
    repeat (6) tick();
    chk("mid_no_stale", longint'(out_valid), 0);
    lat_pair("after_rst", 100, 0, 40, 0, 1024, 0, 1'b0, 1'b0);
    chk("after_rst_X1_r", X1_r, 140);
    chk("after_rst_X2_r", X2_r, 60);
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/butterfly_pipe.md
Name: butterfly_pipe

Overview:
Pipelined, parametrised radix-2 DIF butterfly for the FFT datapath. It computes X1 = x1 + x2 and X2 = (x1 − x2)·W. Over the combinational 12-bit butterfly it adds generic widths, a valid/ready handshake with backpressure, round-half-up, optional saturation, per-sample ½ scaling, inverse-FFT (conjugate twiddle) mode and a sticky overflow flag. It sits between the stage reorder buffers and the twiddle ROM.

Parameters:
DW, 12, data width of each real/imag component (signed two's complement)
TW, 12, twiddle component width (signed)
FRAC, 10, twiddle fractional bits (1.0 = 2^FRAC); must satisfy 1 ≤ FRAC < TW
SAT, 1, 1 = saturate results to DW range; 0 = wrap (keep low DW bits)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input sample pair valid
in_ready  out  1  block can accept input this cycle
x1_r, x1_i, x2_r, x2_i  in  DW each  input operands
w_r, w_i  in  TW each  twiddle
inv  in  1  1 = use conj(W) (inverse FFT); captured with data
scale  in  1  1 = divide both outputs by 2 (extra right shift, rounded); captured with data
out_valid  out  1  output valid
out_ready  in  1  downstream accepts output
X1_r, X1_i, X2_r, X2_i  out  DW each  results
ovf  out  1  sticky: any result clipped (SAT=1) or wrapped (SAT=0)
ovf_clr  in  1  synchronous clear of ovf

Behaviour:
- Handshake: transfer on in_valid&&in_ready and out_valid&&out_ready. Data/inv/scale are sampled only on an input transfer.
- Pipeline: 3 registered stages, each with its own valid bit.
  - S1: sums and differences, DW+1 bits.
  - S2: four products (DW+1)×TW; w_i negated when inv=1 (negate done at TW+1 bits so −2^(TW−1) is exact).
  - S3: combine (ac−bd, ad+bc), round, shift, saturate/wrap into output registers.
- Latency: 3 cycles from input transfer to out_valid with no stall. Throughput is 1 pair per cycle.
- Stall: a stage advances when the next stage is empty or advancing. in_ready = !S1_valid || S1_advances. in_ready must not combinationally depend on in_valid.
- Storage and ordering: with out_ready held low, at most 3 pairs are held. Nothing is dropped or duplicated, and order is preserved.
- Outputs must hold stable while out_valid && !out_ready.
- Arithmetic, sh = FRAC + scale:
  - X2 = (P + 2^(sh−1)) >>> sh, with P computed at full width before reduction.
  - X1 = sum when scale=0; (sum + 1) >>> 1 when scale=1.
  - Rounding is add-half then arithmetic shift, i.e. round half toward +inf.
- Reduction to DW bits:
  - SAT=1: clamp to [−2^(DW−1), 2^(DW−1)−1].
  - SAT=0: take the low DW bits.
  - Either way, ovf sets on any of the four components that did not fit. The flag is evaluated only on S3 load.
- ovf priority: ovf_clr and a new overflow in the same cycle → ovf=1 (set wins).
- Reset (asynchronous, any time including mid-stream):
  - All valid bits, ovf and output data → 0.
  - in_ready = 1 after reset release; out_valid = 0.
  - In-flight samples are discarded.
- Idle cycles: out_valid=0 with out_ready=1 is legal. Data registers may hold stale values; only valid-qualified data is checked.

Test Plan:
- Basic: DW=12, FRAC=10, x1=(100,0), x2=(40,0), W=(1024,0), inv=0, scale=0, out_ready=1 → 3 cycles later X1=(140,0), X2=(60,0), ovf=0.
- Inverse: x1=(100,0), x2=(40,0), W=(0,1024), inv=0 → X2=(0,60); same with inv=1 → X2=(0,−60); X1=(140,0) both times.
- Rounding/scale:
  - x1=(1,0), x2=(0,0), W=(512,0) → X2_r=1 (truncation would give 0).
  - x1=(0,0), x2=(1,0), W=(512,0) → X2_r=0.
  - x1=(101,0), x2=(0,0), W=(1024,0), scale=1 → X1_r=51, X2_r=51.
- Saturation: x1_r=x2_r=2047 → SAT=1: X1_r=2047, ovf=1; SAT=0: X1_r=−2, ovf=1. ovf_clr pulse → ovf=0 next cycle.
- Backpressure: stream 6 back-to-back pairs, out_ready low for cycles 2–8 → in_ready low once 3 pairs are held. All 6 outputs emerge in order, none lost or duplicated, and outputs stay stable while stalled.
- Reset mid-stream: assert rst_n=0 with 2 pairs in flight → out_valid=0 and ovf=0 immediately (asynchronous). After release, in_ready=1 and no stale outputs appear; a new pair returns after 3 cycles.
